// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : uart_pkg
//  Description : Shared constants and types for the UART transmit controller:
//                state encodings, default widths, line-level constants and
//                the frame-configuration snapshot type.
//  Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

    // Default geometry
    localparam int c_BAUD_W_DEF     = 20;
    localparam int c_FRAME_BITS_DEF = 11;

    // Controller states (explicit 2-bit encoding)
    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_LOAD  = 2'd1;
    localparam logic [1:0] c_ST_SHIFT = 2'd2;

    // Line levels
    localparam logic c_LINE_IDLE = 1'b1;
    localparam logic c_START_BIT = 1'b0;

    // Frame configuration captured on the accepted write
    typedef struct packed {
        logic eight;
        logic pen;
        logic ohel;
    } frame_cfg_t;

endpackage
`default_nettype wire

// File: rtl/bit_9_10_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : bit_9_10_decoder
//  Description : Forms frame bits 9 and 10 from the captured byte and the
//                frame-configuration snapshot (7/8 data bits, parity enable,
//                odd/even parity sense). Purely combinational.
//  Revision    : 1.0 - initial release
// ============================================================================
module bit_9_10_decoder (
    input  logic [7:0] i_ldata,
    input  logic       i_eight,
    input  logic       i_pen,
    input  logic       i_ohel,
    output logic       o_bit_nine,
    output logic       o_bit_ten
);

    logic w_par7;
    logic w_par8;

    // Even parity over the transmitted data bits; ohel=1 flips it to odd
    assign w_par7 = ^i_ldata[6:0];
    assign w_par8 = ^i_ldata;

    // Select which of data bit 7, parity or stop-level ones fill bits 9 and 10
    always_comb begin
        o_bit_nine = 1'b1;
        o_bit_ten  = 1'b1;
        if (i_eight) begin
            o_bit_nine = i_ldata[7];
            if (i_pen) begin
                o_bit_ten = w_par8 ^ i_ohel;
            end
        end else if (i_pen) begin
            o_bit_nine = w_par7 ^ i_ohel;
        end
    end

endmodule
`default_nettype wire

// File: rtl/uart_tx_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : uart_tx_ctrl
//  Description : UART transmit controller. Accepts one byte per write while
//                idle, snapshots the frame configuration, loads an 11-bit
//                frame into a shift register and shifts it out LSB-first on
//                a programmable baud tick. txrdy reports idle to the CPU.
//                Optional macro UART_TX_BREAK_EN adds a 'brk' input that
//                holds the line low while idle.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_ctrl
    import uart_pkg::*;
#(
    parameter int BAUD_W     = c_BAUD_W_DEF,
    parameter int FRAME_BITS = c_FRAME_BITS_DEF
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              load,
    input  logic [7:0]        out_port,
    input  logic              eight,
    input  logic              pen,
    input  logic              ohel,
    input  logic [BAUD_W-1:0] baud_k,
`ifdef UART_TX_BREAK_EN
    input  logic              brk,
`endif
    output logic              tx,
    output logic              txrdy
);

    localparam int c_BCNT_W = $clog2(FRAME_BITS + 1);

    logic [1:0]            r_state;
    logic [1:0]            w_state_next;
    logic [7:0]            r_ldata;
    frame_cfg_t            r_cfg;
    logic [FRAME_BITS-1:0] r_shift;
    logic [FRAME_BITS-1:0] w_sr_load;
    logic [BAUD_W-1:0]     r_baud_cnt;
    logic [BAUD_W-1:0]     w_baud_max;
    logic [c_BCNT_W-1:0]   r_bit_cnt;
    logic                  r_txrdy;
    logic                  r_brk;
    logic                  w_brk;
    logic                  w_accept;
    logic                  w_tick;
    logic                  w_done;
    logic                  w_bit_nine;
    logic                  w_bit_ten;

`ifdef UART_TX_BREAK_EN
    assign w_brk = brk;
`else
    assign w_brk = 1'b0;
`endif

    bit_9_10_decoder u_dec (
        .i_ldata    (r_ldata),
        .i_eight    (r_cfg.eight),
        .i_pen      (r_cfg.pen),
        .i_ohel     (r_cfg.ohel),
        .o_bit_nine (w_bit_nine),
        .o_bit_ten  (w_bit_ten)
    );

    // Frame image: idle slot first, then start bit, 7 data bits, bits 9/10
    assign w_sr_load = FRAME_BITS'({w_bit_ten, w_bit_nine, r_ldata[6:0],
                                    c_START_BIT, c_LINE_IDLE});

    // baud_k=0 behaves as 1 (tick every clock)
    assign w_baud_max = (baud_k == '0) ? '0 : (baud_k - BAUD_W'(1));

    // State register
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic, write acceptance, baud tick and frame-complete strobe.
    // The tick uses >= so that lowering baud_k mid-frame ends the current bit
    // promptly instead of waiting for the counter to wrap.
    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        w_tick       = 1'b0;
        w_done       = 1'b0;
        case (r_state)
            c_ST_IDLE: begin
                w_accept = load & r_txrdy & ~w_brk;
                if (w_accept) begin
                    w_state_next = c_ST_LOAD;
                end
            end
            c_ST_LOAD: begin
                w_state_next = c_ST_SHIFT;
            end
            c_ST_SHIFT: begin
                w_tick = (r_baud_cnt >= w_baud_max);
                if (w_tick && (r_bit_cnt == c_BCNT_W'(FRAME_BITS - 1))) begin
                    w_done       = 1'b1;
                    w_state_next = c_ST_IDLE;
                end
            end
            default: begin
                w_state_next = c_ST_IDLE;
            end
        endcase
    end

    // Datapath: byte/config capture, shift register, baud and bit counters, txrdy
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_ldata    <= '0;
            r_cfg      <= '0;
            r_shift    <= '1;
            r_baud_cnt <= '0;
            r_bit_cnt  <= '0;
            r_txrdy    <= 1'b1;
            r_brk      <= 1'b0;
        end else begin
            if (w_accept) begin
                r_ldata <= out_port;
                r_cfg   <= '{eight: eight, pen: pen, ohel: ohel};
            end

            case (r_state)
                c_ST_LOAD: begin
                    r_shift    <= w_sr_load;
                    r_baud_cnt <= '0;
                    r_bit_cnt  <= '0;
                end
                c_ST_SHIFT: begin
                    if (w_tick) begin
                        r_baud_cnt <= '0;
                        r_shift    <= {c_LINE_IDLE, r_shift[FRAME_BITS-1:1]};
                        r_bit_cnt  <= r_bit_cnt + c_BCNT_W'(1);
                    end else begin
                        r_baud_cnt <= r_baud_cnt + BAUD_W'(1);
                    end
                end
                default: begin
                end
            endcase

            if (w_accept) begin
                r_txrdy <= 1'b0;
            end else if (w_done) begin
                r_txrdy <= 1'b1;
            end else if (r_state == c_ST_IDLE) begin
                // Break only acts between frames; it also blocks writes
                r_txrdy <= ~w_brk;
            end

            r_brk <= (r_state == c_ST_IDLE) && !w_accept && w_brk;
        end
    end

`ifdef UART_TX_BREAK_EN
    assign tx = r_shift[0] & ~r_brk;
`else
    assign tx = r_shift[0];
`endif
    assign txrdy = r_txrdy;

endmodule
`default_nettype wire
